// File: rtl/fft_out_reorder.sv
// Converts a parallel 8-point FFT butterfly frame (bit-reversed element order) into a
// natural-order beat stream through a ping-pong frame buffer. Optional macro: FFT_OUT_SCALE_EN.
module fft_out_reorder #(
  parameter int W = 25
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [7:0][2*W-1:0]    frame_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*W-1:0]         out_data_o,
  output logic [2:0]             out_idx_o,
  output logic                   out_last_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                  state_q;
  logic [1:0]              full_q;
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [2:0]              k_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [1:0][7:0][2*W-1:0] buf_q;

  logic                    in_hs;
  logic                    out_hs;
  logic                    next_frame_ready;
  logic [2*W-1:0]          sel_word;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  function automatic logic [W-1:0] scale(input logic [W-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    return W'($signed(x) >>> 3);
`else
    return x;
`endif
  endfunction

  // Ready derives only from the full flags so it never combinationally follows in_valid_i.
  assign in_ready_o = ~(full_q[0] & full_q[1]);
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_q & out_ready_i;

  // A frame captured on the same edge as the last beat keeps the stream contiguous.
  assign next_frame_ready = full_q[~rd_ptr_q] | in_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      full_q      <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      k_q         <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (in_hs) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      case (state_q)
        S_IDLE: begin
          if (in_hs) begin
            state_q     <= S_STREAM;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            k_q         <= 3'd0;
          end
        end
        S_STREAM: begin
          if (out_hs) begin
            if (k_q == 3'd7) begin
              full_q[rd_ptr_q] <= 1'b0;
              rd_ptr_q         <= ~rd_ptr_q;
              k_q              <= 3'd0;
              out_last_q       <= 1'b0;
              if (!next_frame_ready) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              k_q        <= k_q + 3'd1;
              out_last_q <= (k_q == 3'd6);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage carries no reset; validity lives entirely in full_q.
  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      buf_q[wr_ptr_q] <= frame_i;
    end
  end

  assign sel_word    = buf_q[rd_ptr_q][bitrev3(k_q)];
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_idx_o   = k_q;
  assign out_data_o  = out_valid_q ? {scale(sel_word[2*W-1:W]), scale(sel_word[W-1:0])}
                                   : '0;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed self-checking bench for fft_out_reorder: ordering, latency, back-to-back,
// stalls, buffer backpressure, mid-frame reset and optional output scaling.
module tb_fft_out_reorder;
  localparam int W = 25;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [7:0][2*W-1:0] frame;
  logic                out_valid;
  logic                out_ready;
  logic [2*W-1:0]      out_data;
  logic [2:0]          out_idx;
  logic                out_last;

  int n_cmp = 0;
  int n_err = 0;

  fft_out_reorder #(.W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .frame_i     (frame),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element j carries re = base+j, im = -(base+j).
  function automatic logic [7:0][2*W-1:0] mk_frame(input int base);
    logic [7:0][2*W-1:0] f;
    logic [W-1:0] re, im;
    for (int j = 0; j < 8; j++) begin
      re   = W'(base + j);
      im   = W'(-(base + j));
      f[j] = {re, im};
    end
    return f;
  endfunction

  function automatic logic [W-1:0] sc(input logic [W-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    return W'($signed(x) >>> 3);
`else
    return x;
`endif
  endfunction

  // Natural-order beat k comes from element bitrev3(k).
  function automatic logic [2*W-1:0] exp_word(input int base, input int k);
    logic [2:0] kk;
    logic [2:0] j;
    logic [W-1:0] re, im;
    kk = 3'(k);
    j  = {kk[0], kk[1], kk[2]};
    re = W'(base + int'(j));
    im = W'(-(base + int'(j)));
    return {sc(re), sc(im)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frame = '0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", out_last); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    frame     = mk_frame(1);
    in_valid  = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid k=%0d: got %b expected 1", k, out_valid); end
      n_cmp++; if (out_data !== exp_word(1, k)) begin n_err++; $display("FAIL single_data k=%0d: got %h expected %h", k, out_data, exp_word(1, k)); end
      n_cmp++; if (out_idx !== 3'(k)) begin n_err++; $display("FAIL single_idx: got %0d expected %0d", out_idx, k); end
      n_cmp++; if (out_last !== (k == 7)) begin n_err++; $display("FAIL single_last k=%0d: got %b expected %b", k, out_last, (k == 7)); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_post_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_post_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int base, k;
    logic exp_rdy;
    out_ready = 1'b1;
    frame     = mk_frame(10);
    in_valid  = 1'b1;
    @(negedge clk);
    frame = mk_frame(20);
    for (int b = 0; b < 16; b++) begin
      base    = (b < 8) ? 10 : 20;
      k       = b % 8;
      exp_rdy = !(b >= 1 && b <= 7);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid b=%0d: got %b expected 1", b, out_valid); end
      n_cmp++; if (out_data !== exp_word(base, k)) begin n_err++; $display("FAIL b2b_data b=%0d: got %h expected %h", b, out_data, exp_word(base, k)); end
      n_cmp++; if (out_idx !== 3'(k)) begin n_err++; $display("FAIL b2b_idx b=%0d: got %0d expected %0d", b, out_idx, k); end
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_in_ready b=%0d: got %b expected %b", b, in_ready, exp_rdy); end
      if (b == 1) in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_post_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    int k_exp;
    int c;
    out_ready = 1'b1;
    frame     = mk_frame(30);
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k_exp    = 0;
    c        = 0;
    while (k_exp < 8 && c < 20) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid c=%0d: got %b expected 1", c, out_valid); end
      n_cmp++; if (out_data !== exp_word(30, k_exp)) begin n_err++; $display("FAIL stall_data c=%0d: got %h expected %h", c, out_data, exp_word(30, k_exp)); end
      n_cmp++; if (out_idx !== 3'(k_exp)) begin n_err++; $display("FAIL stall_idx c=%0d: got %0d expected %0d", c, out_idx, k_exp); end
      out_ready = !(c == 1 || c == 2);
      @(negedge clk);
      if (out_ready) k_exp++;
      c++;
    end
    out_ready = 1'b1;
    n_cmp++; if (c !== 10) begin n_err++; $display("FAIL stall_cycles: got %0d expected 10", c); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_post_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int base, k;
    logic exp_rdy;
    out_ready = 1'b0;
    frame     = mk_frame(40);
    in_valid  = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy_a: got %b expected 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy_b: got %b expected 1", in_ready); end
    frame = mk_frame(50);
    @(negedge clk);
    frame = mk_frame(60);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy_full i=%0d: got %b expected 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid i=%0d: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== exp_word(40, 0)) begin n_err++; $display("FAIL bp_hold_data i=%0d: got %h expected %h", i, out_data, exp_word(40, 0)); end
      n_cmp++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL bp_hold_idx i=%0d: got %0d expected 0", i, out_idx); end
      if (i < 2) @(negedge clk);
    end
    for (int m = 0; m < 24; m++) begin
      base    = (m < 8) ? 40 : ((m < 16) ? 50 : 60);
      k       = m % 8;
      exp_rdy = (m == 8) || (m >= 16);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid m=%0d: got %b expected 1", m, out_valid); end
      n_cmp++; if (out_data !== exp_word(base, k)) begin n_err++; $display("FAIL bp_data m=%0d: got %h expected %h", m, out_data, exp_word(base, k)); end
      n_cmp++; if (out_idx !== 3'(k)) begin n_err++; $display("FAIL bp_idx m=%0d: got %0d expected %0d", m, out_idx, k); end
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready m=%0d: got %b expected %b", m, in_ready, exp_rdy); end
      if (m == 0) out_ready = 1'b1;
      if (m == 9) in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_post_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    frame     = mk_frame(70);
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_idx !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_idx: got %0d expected 3", out_idx); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL rstmid_idx: got %0d expected 0", out_idx); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rstmid_last: got %b expected 0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: got %b expected 0", out_valid); end
    frame    = mk_frame(80);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_new_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL rstmid_new_idx: got %0d expected 0", out_idx); end
    n_cmp++; if (out_data !== exp_word(80, 0)) begin n_err++; $display("FAIL rstmid_new_data: got %h expected %h", out_data, exp_word(80, 0)); end
    repeat (8) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_post_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_scale();
    logic [W-1:0] re, im, ex_re, ex_im;
    logic [7:0][2*W-1:0] f;
    f  = mk_frame(0);
    re = W'(80);
    im = '1;
    f[0] = {re, im};
`ifdef FFT_OUT_SCALE_EN
    ex_re = W'(10);
`else
    ex_re = W'(80);
`endif
    ex_im     = '1;
    out_ready = 1'b1;
    frame     = f;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_data !== {ex_re, ex_im}) begin n_err++; $display("FAIL scale_beat0: got %h expected %h", out_data, {ex_re, ex_im}); end
    repeat (8) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL scale_post_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_scale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter W, default 25, giving the signed two's-complement width of each complex component.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port in_valid_i, input, 1, parallel frame present.
REQ-005 SHALL have port in_ready_o, output, 1, frame accepted when in_valid_i and in_ready_o are both high.
REQ-006 SHALL have port frame_i, input, 8 x 2W, butterfly output frame; each element packs {re[2W-1:W], im[W-1:0]}; element j holds bin bitrev3(j).
REQ-007 SHALL have port out_valid_o, output, 1, out_data_o valid.
REQ-008 SHALL have port out_ready_i, input, 1, sink accepts a beat when out_valid_o and out_ready_i are both high.
REQ-009 SHALL have port out_data_o, output, 2W, one complex bin in natural order, same packing as frame_i.
REQ-010 SHALL have port out_idx_o, output, 3, bin index k of out_data_o.
REQ-011 SHALL have port out_last_o, output, 1, high on beat k=7.

Function
REQ-012 SHALL hold two frame buffers (ping-pong), each with a full flag; frames are written in arrival order and read in arrival order.
REQ-013 SHALL drive in_ready_o = 1 when at least one buffer is free; in_ready_o SHALL depend on registered state only, not on in_valid_i or out_ready_i.
REQ-014 SHALL capture all 8 frame_i elements in one cycle on an input handshake and set that buffer's full flag.
REQ-015 SHALL use a read state machine with states IDLE (no full buffer, out_valid_o=0) and STREAM (out_valid_o=1); IDLE->STREAM when a buffer becomes full; STREAM->IDLE on the k=7 handshake when no other buffer is full; otherwise it stays in STREAM and moves to the next buffer with k=0.
REQ-016 SHALL assert out_valid_o on the cycle after the capturing edge; the first beat latency is 1 cycle.
REQ-017 SHALL keep a 3-bit beat counter k; in STREAM, out_data_o = buffer[bitrev3(k)] (order 0,4,2,6,1,5,3,7); out_idx_o = k.
REQ-018 SHALL advance k only on an output handshake; k wraps 7->0 and releases the buffer on that same edge.
REQ-019 SHALL hold out_data_o, out_idx_o, and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL, when an input handshake and the k=7 output handshake occur on the same edge, both release the old buffer and capture the new one with no lost beat; back-to-back frames SHALL stream 16 contiguous beats with out_ready_i held at 1.
REQ-021 SHALL never overwrite a full buffer; when in_ready_o=0, in_valid_i is ignored.

Reset
REQ-022 SHALL, while rst_i=1, immediately force out_valid_o=0, out_last_o=0, out_idx_o=0, out_data_o=0, in_ready_o=1, clear both full flags and k, set the read and write pointers to buffer 0, and set the state to IDLE.
REQ-023 SHALL discard any partially streamed frame when reset asserts mid-operation; after release, the first accepted frame SHALL start at k=0.

Configuration
REQ-024 SHALL, with macro FFT_OUT_SCALE_EN defined, output each component arithmetic-shifted right by 3 (divide by 8, floor, sign kept, width W); without it, components SHALL pass unmodified.

Verification
REQ-025 Frame with element j = {re=j+1, im=-(j+1)} and out_ready_i=1 -> re sequence 1,5,3,7,2,6,4,8 with idx 0..7, out_valid_o first high 1 cycle after accept, out_last_o only on idx 7.
REQ-026 Two frames offered back-to-back with out_ready_i=1 -> 16 contiguous valid beats; in_ready_o low only while both buffers are full; no beat dropped or duplicated.
REQ-027 out_ready_i toggled 1,0,0,1 during a frame -> out_data_o/out_idx_o held during the 0 cycles; order is unchanged.
REQ-028 Three frames offered with out_ready_i=0 -> first two accepted, in_ready_o=0 for the third until the k=7 beat of the first completes.
REQ-029 rst_i pulsed at k=3 -> outputs zero asynchronously, in_ready_o=1; the next frame streams from idx 0.
REQ-030 FFT_OUT_SCALE_EN defined, element 0 = {re=80, im=-1} -> beat 0 = {re=10, im=-1}; undefined -> {80, -1}.
